tx_route_logic: RTL and testbench

Downstream stage of the per-router input FIFO. Pops one data item (single-flit packet) at a time, computes its output port with dimension-ordered XY routing against this router's coordinates, and delivers it to one of 5 neighbouring receivers over a two-phase req/ack handshake. At most one outstanding item per output port; strict FIFO order, so a busy target port stalls the queue.

---
 rtl/tx_route_logic.sv | 119 +++++++++++
 tb/tb_tx_route_logic.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tx_route_logic.sv
// tx_route_logic
// Pops single-flit packets from a first-word-fall-through FIFO, picks an
// output port with dimension-ordered XY routing and hands each item to one
// of five receivers over a two-phase (toggle) req/ack handshake.
// Each port is implicitly idle (req == ack) or waiting for an ack
// (req != ack); a busy target port stalls the queue in strict FIFO order.
module tx_route_logic #(
  parameter int SIZE    = 8,
  parameter int COORD_W = 2,
  parameter int X_ADDR  = 0,
  parameter int Y_ADDR  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fifo_empty,
  input  logic [SIZE-1:0]     fifo_data_out,
  output logic                fifo_read,
  output logic [4:0]          tx_req,
  input  logic [4:0]          tx_ack,
  output logic [SIZE*5-1:0]   tx_data
);

  // Port numbering used on tx_req / tx_ack / tx_data slices.
  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_SOUTH = 3'd2;
  localparam logic [2:0] PORT_EAST  = 3'd3;
  localparam logic [2:0] PORT_WEST  = 3'd4;

  // Router coordinates narrowed to the width of the destination fields.
  localparam logic [COORD_W-1:0] X_C = COORD_W'(X_ADDR);
  localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_ADDR);

  // XY routing: resolve X first, then Y, otherwise deliver locally.
  function automatic logic [2:0] xy_route(input logic [SIZE-1:0] item);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [2:0]         port;
    dx = item[SIZE-1 -: COORD_W];
    dy = item[SIZE-1-COORD_W -: COORD_W];
    if (dx > X_C) begin
      port = PORT_EAST;
    end else if (dx < X_C) begin
      port = PORT_WEST;
    end else if (dy > Y_C) begin
      port = PORT_NORTH;
    end else if (dy < Y_C) begin
      port = PORT_SOUTH;
    end else begin
      port = PORT_LOCAL;
    end
    return port;
  endfunction

  logic [4:0]        tx_req_q;
  logic [4:0]        tx_req_d;
  logic [SIZE*5-1:0] tx_data_q;
  logic [SIZE*5-1:0] tx_data_d;

  logic [2:0]        port_s;
  logic [4:0]        busy_s;
  logic              port_busy_s;
  logic              send_s;

  // Route decision and send qualification from this cycle's head item.
  always_comb begin
    port_s      = xy_route(fifo_data_out);
    busy_s      = tx_req_q ^ tx_ack;
    port_busy_s = 1'b1;
    case (port_s)
      PORT_LOCAL: port_busy_s = busy_s[0];
      PORT_NORTH: port_busy_s = busy_s[1];
      PORT_SOUTH: port_busy_s = busy_s[2];
      PORT_EAST:  port_busy_s = busy_s[3];
      PORT_WEST:  port_busy_s = busy_s[4];
      default:    port_busy_s = 1'b1;
    endcase
    // Pop is combinational so the FIFO advances on the same edge as the
    // send; a registered pop would re-send the head item.
    send_s = reset & ~fifo_empty & ~port_busy_s;
  end

  // Next state: a send toggles only the selected req bit and reloads only
  // its data slice; every other port holds.
  always_comb begin
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    if (send_s) begin
      for (int k = 0; k < 5; k++) begin
        if (port_s == 3'(k)) begin
          tx_req_d[k]               = ~tx_req_q[k];
          tx_data_d[SIZE*k +: SIZE] = fifo_data_out;
        end else begin
          tx_req_d[k]               = tx_req_q[k];
          tx_data_d[SIZE*k +: SIZE] = tx_data_q[SIZE*k +: SIZE];
        end
      end
    end else begin
      tx_req_d  = tx_req_q;
      tx_data_d = tx_data_q;
    end
  end

  // Output registers; reset abandons any pending transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_req_q  <= 5'b00000;
      tx_data_q <= {(SIZE*5){1'b0}};
    end else begin
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign fifo_read = send_s;
  assign tx_req    = tx_req_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_tx_route_logic.sv
// Directed testbench for tx_route_logic (SIZE=8, COORD_W=2, X=1, Y=1).
// A queue models the FIFO; expected values are hand-computed constants.
module tb_tx_route_logic;

  logic        clk;
  logic        reset;
  logic        fifo_empty;
  logic [7:0]  fifo_data_out;
  logic        fifo_read;
  logic [4:0]  tx_req;
  logic [4:0]  tx_ack;
  logic [39:0] tx_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] fifo_q[$];

  tx_route_logic #(
    .SIZE(8), .COORD_W(2), .X_ADDR(1), .Y_ADDR(1)
  ) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out), .fifo_read(fifo_read),
    .tx_req(tx_req), .tx_ack(tx_ack), .tx_data(tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present FIFO head; garbage data while empty must be ignored.
  task automatic update_fifo();
    fifo_empty    = (fifo_q.size() == 0);
    fifo_data_out = (fifo_q.size() != 0) ? fifo_q[0] : 8'hA7;
  endtask

  // One clock: pop the model FIFO if the DUT strobed fifo_read this cycle.
  task automatic tick();
    logic rd;
    rd = fifo_read;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    update_fifo();
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset  = 1'b0;
    tx_ack = 5'b00000;
    fifo_q.push_back(8'hC5);
    update_fifo();
    @(posedge clk);
    #1;

    // Reset held with a valid head item: nothing may move.
    for (int i = 0; i < 2; i++) begin
      settle();
      check_eq("rst_rd", 64'(fifo_read), 64'd0);
      tick();
      check_eq("rst_req", 64'(tx_req), 64'd0);
      check_eq("rst_data", 64'(tx_data), 64'd0);
    end
    check_eq("rst_no_pop", 64'(fifo_q.size()), 64'd1);

    // East route: C5 -> port 3.
    reset = 1'b1;
    settle();
    check_eq("east_rd", 64'(fifo_read), 64'd1);
    tick();
    check_eq("east_req", 64'(tx_req), 64'(5'b01000));
    check_eq("east_data", 64'(tx_data), 64'(40'h00C5000000));
    check_eq("east_empty_rd", 64'(fifo_read), 64'd0);

    // Local route: 5A -> port 0, then ack it.
    fifo_q.push_back(8'h5A);
    update_fifo();
    settle();
    check_eq("local_rd", 64'(fifo_read), 64'd1);
    tick();
    check_eq("local_req", 64'(tx_req), 64'(5'b01001));
    check_eq("local_data", 64'(tx_data), 64'(40'h00C500005A));
    tx_ack = 5'b00001;
    settle();
    tick();
    check_eq("ack_req", 64'(tx_req), 64'(5'b01001));
    check_eq("ack_data", 64'(tx_data), 64'(40'h00C500005A));
    check_eq("ack_rd", 64'(fifo_read), 64'd0);

    // Back-to-back: 60 -> north, 40 -> south, 00 -> west.
    fifo_q.push_back(8'h60);
    fifo_q.push_back(8'h40);
    fifo_q.push_back(8'h00);
    update_fifo();
    settle();
    check_eq("b2b_rd0", 64'(fifo_read), 64'd1);
    tick();
    check_eq("b2b_req1", 64'(tx_req), 64'(5'b01011));
    check_eq("b2b_rd1", 64'(fifo_read), 64'd1);
    tick();
    check_eq("b2b_req2", 64'(tx_req), 64'(5'b01111));
    check_eq("b2b_rd2", 64'(fifo_read), 64'd1);
    tick();
    check_eq("b2b_req3", 64'(tx_req), 64'(5'b11111));
    check_eq("b2b_data", 64'(tx_data), 64'(40'h00C540605A));
    check_eq("b2b_rd3", 64'(fifo_read), 64'd0);

    // Head-of-line blocking: free all ports, send C5, block D1 behind it.
    tx_ack = 5'b11111;
    fifo_q.push_back(8'hC5);
    fifo_q.push_back(8'hD1);
    update_fifo();
    settle();
    check_eq("hol_rd0", 64'(fifo_read), 64'd1);
    tick();
    check_eq("hol_req0", 64'(tx_req), 64'(5'b10111));
    for (int i = 0; i < 3; i++) begin
      check_eq("hol_blk_rd", 64'(fifo_read), 64'd0);
      tick();
    end
    check_eq("hol_blk_data", 64'(tx_data), 64'(40'h00C540605A));
    check_eq("hol_blk_req", 64'(tx_req), 64'(5'b10111));
    check_eq("hol_no_pop", 64'(fifo_q.size()), 64'd1);
    tx_ack = 5'b10111;
    settle();
    check_eq("hol_ack_rd", 64'(fifo_read), 64'd1);
    tick();
    check_eq("hol_req1", 64'(tx_req), 64'(5'b11111));
    check_eq("hol_data1", 64'(tx_data), 64'(40'h00D140605A));
    check_eq("hol_drained", 64'(fifo_q.size()), 64'd0);

    // Reset while port 3 waits for its ack.
    reset  = 1'b0;
    tx_ack = 5'b00000;
    settle();
    check_eq("mrst_rd", 64'(fifo_read), 64'd0);
    tick();
    check_eq("mrst_req", 64'(tx_req), 64'd0);
    check_eq("mrst_data", 64'(tx_data), 64'd0);
    reset = 1'b1;
    fifo_q.push_back(8'hC5);
    update_fifo();
    settle();
    check_eq("post_rd", 64'(fifo_read), 64'd1);
    tick();
    check_eq("post_req", 64'(tx_req), 64'(5'b01000));
    check_eq("post_data", 64'(tx_data), 64'(40'h00C5000000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
